regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_pkg.sv | 16 +
 rtl/regdst_sel.sv | 21 ++
 rtl/regwb_arbiter.sv | 125 ++++++++++++
 tb/tb_regwb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// ============================================================================
// Module  : regwb_pkg
// Purpose : Shared constants for the register-file writeback arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package regwb_pkg;
  localparam int   REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int   DROP_CNT_W = 8;
  localparam logic REQ_ALU    = 1'b0;
  localparam logic REQ_MEM    = 1'b1;
endpackage

`default_nettype wire

// File: rtl/regdst_sel.sv
// ============================================================================
// Module  : regdst_sel
// Purpose : Destination register select, rt or rd chosen by regdst.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module regdst_sel
  import regwb_pkg::*;
(
  input  logic                  regdst_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic [REG_ADDR_W-1:0] dst_o
);

  assign dst_o = regdst_i ? rd_i : rt_i;

endmodule

`default_nettype wire

// File: rtl/regwb_arbiter.sv
// ============================================================================
// Module  : regwb_arbiter
// Purpose : Round-robin arbiter of ALU/MEM writebacks into one RF write port.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req0_rt,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [REG_ADDR_W-1:0] req1_rt,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic                  req0_regdst,
  input  logic                  req1_regdst,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  last_grant,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [REG_ADDR_W-1:0] w_dst0, w_dst1, w_dst;
  logic [DATA_W-1:0]     w_data;
  logic                  w_xfer, w_drop, w_gnt;

  logic                  rf_we_q,      rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q,   rf_wdata_d;
  logic                  last_grant_q, last_grant_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q,   drop_cnt_d;

  regdst_sel u_sel0 (
    .regdst_i (req0_regdst),
    .rt_i     (req0_rt),
    .rd_i     (req0_rd),
    .dst_o    (w_dst0)
  );

  regdst_sel u_sel1 (
    .regdst_i (req1_regdst),
    .rt_i     (req1_rt),
    .rd_i     (req1_rd),
    .dst_o    (w_dst1)
  );

  // On contention the requester that did not win last time goes first.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && req1_valid) begin
        req0_ready = (last_grant_q == REQ_MEM);
        req1_ready = (last_grant_q == REQ_ALU);
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign w_xfer = req0_ready | req1_ready;
  assign w_gnt  = req1_ready ? REQ_MEM : REQ_ALU;
  assign w_dst  = req1_ready ? w_dst1 : w_dst0;
  assign w_data = req1_ready ? req1_data : req0_data;
  assign w_drop = w_xfer && ZERO_SUPPRESS && (w_dst == ZERO_REG);

  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    drop_cnt_d   = drop_cnt_q;
    if (w_xfer) begin
      last_grant_d = w_gnt;
      if (w_drop) begin
        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
      end else begin
        rf_we_d    = 1'b1;
        rf_waddr_d = w_dst;
        rf_wdata_d = w_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= REQ_MEM;
      drop_cnt_q   <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign last_grant = last_grant_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
// ============================================================================
// Module  : tb_regwb_arbiter
// Purpose : Directed and random checks of regwb_arbiter against a reference.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regwb_arbiter;

  logic        clk, rst, stall;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rt, req0_rd, req1_rt, req1_rd;
  logic        req0_regdst, req1_regdst;
  logic [31:0] req0_data, req1_data;
  logic        rf_we, last_grant;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic        m_lg, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  regwb_arbiter #(.DATA_W(32), .ZERO_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_rt(req0_rt), .req0_rd(req0_rd), .req1_rt(req1_rt), .req1_rd(req1_rd),
    .req0_regdst(req0_regdst), .req1_regdst(req1_regdst),
    .req0_data(req0_data), .req1_data(req1_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .last_grant(last_grant), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lg = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    rf_we,      0);
    check({tag, "_addr"},  rf_waddr,   0);
    check({tag, "_data"},  rf_wdata,   0);
    check({tag, "_lg"},    last_grant, 1);
    check({tag, "_cnt"},   drop_cnt,   0);
    check({tag, "_rdy0"},  req0_ready, 0);
    check({tag, "_rdy1"},  req1_ready, 0);
  endtask

  // Called shortly after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    logic e0, e1, winner;
    logic [4:0] dst;
    e0 = 1'b0; e1 = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && req1_valid) begin
        winner = !m_lg;
        e0 = (winner == 1'b0);
        e1 = (winner == 1'b1);
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    #1;
    check({tag, "_rdy0"}, req0_ready, e0);
    check({tag, "_rdy1"}, req1_ready, e1);
    @(posedge clk);
    if (e0 || e1) begin
      dst  = e1 ? (req1_regdst ? req1_rd : req1_rt) : (req0_regdst ? req0_rd : req0_rt);
      m_lg = e1;
      if (dst == 5'd0) begin
        m_we = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_we   = 1'b1;
        m_addr = dst;
        m_data = e1 ? req1_data : req0_data;
      end
    end else begin
      m_we = 1'b0;
    end
    #1;
    check({tag, "_we"},  rf_we,      m_we);
    check({tag, "_lg"},  last_grant, m_lg);
    check({tag, "_cnt"}, drop_cnt,   m_cnt[7:0]);
    if (m_we) begin
      check({tag, "_addr"}, rf_waddr, m_addr);
      check({tag, "_data"}, rf_wdata, m_data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_rt = 0; req0_rd = 0; req1_rt = 0; req1_rd = 0;
    req0_regdst = 0; req1_regdst = 0;
    req0_data = 0; req1_data = 0;
    model_reset();
    #1;
    do_reset();

    // Single requester, rd selected
    req0_valid = 1; req0_rt = 5; req0_rd = 9; req0_regdst = 1; req0_data = 32'h1234;
    cycle("single");
    check("single_addr9", rf_waddr, 9);
    check("single_data", rf_wdata, 32'h1234);
    req0_valid = 0;
    cycle("idle");

    // Contention right after reset: 0,1,0,1
    do_reset();
    req0_valid = 1; req0_rd = 7; req0_regdst = 1; req0_data = 32'hAAAA_0000;
    req1_valid = 1; req1_rt = 12; req1_regdst = 0; req1_data = 32'hBBBB_1111;
    for (int i = 0; i < 4; i++) begin
      cycle("rr");
      check("rr_order", last_grant, i % 2);
      check("rr_waddr", rf_waddr, (i % 2 == 0) ? 7 : 12);
    end

    // Register-0 drops and counter saturation
    req0_valid = 0;
    req1_valid = 1; req1_rt = 0; req1_regdst = 0;
    cycle("drop1");
    check("drop_first", drop_cnt, 1);
    for (int i = 0; i < 299; i++) cycle("drop");
    check("drop_sat", drop_cnt, 255);

    // Stall with both valid, then release
    req1_rt = 3; req0_valid = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) cycle("stall");
    stall = 0;
    cycle("unstall");

    // Async reset one cycle after a transfer
    req1_valid = 0; req0_valid = 1;
    cycle("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    check("arst_hold_we", rf_we, 0);
    rst = 1'b0;
    model_reset();

    // Alternating single-valid, no bubbles
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i % 2 == 0);
      req1_valid = (i % 2 == 1);
      req0_data  = 32'h100 + i;
      req1_data  = 32'h200 + i;
      cycle("alt");
      check("alt_we", rf_we, 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid  = $urandom_range(0, 1);
      req1_valid  = $urandom_range(0, 1);
      stall       = ($urandom_range(0, 3) == 0);
      req0_rt     = $urandom_range(0, 31); req0_rd = $urandom_range(0, 31);
      req1_rt     = $urandom_range(0, 31); req1_rd = $urandom_range(0, 31);
      req0_regdst = $urandom_range(0, 1);  req1_regdst = $urandom_range(0, 1);
      req0_data   = $urandom;              req1_data = $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
